// File: rtl/regfile_write_arbiter.sv
// Two-source register-file write arbiter with a one-entry skid buffer.
// Port A (ALU) wins a same-cycle conflict; the losing port B (load unit)
// request is parked in the holding register and issued on the following
// cycle, so same-address writes land in order A then B.
// Optional feature: define REGFILE_WR_ZERO_PROTECT_EN to make register 0
// read-only (issues to address 0 keep their slot but raise no write strobe).
module regfile_write_arbiter #(
    parameter  int ADDR_W = 3,
    parameter  int DATA_W = 16,
    localparam int NREG   = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              wr_en,
    output logic [NREG-1:0]   wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              hold_full
);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   hold_addr;
    logic [DATA_W-1:0]   hold_data;

    logic                issue;
    logic                capture;
    logic                issue_en;
    logic [ADDR_W-1:0]   issue_addr;
    logic [DATA_W-1:0]   issue_data;
    logic [NREG-1:0]     issue_sel;

    // Readies depend on the state only, never on the incoming valids.
    assign a_ready   = (state == EMPTY);
    assign b_ready   = (state == EMPTY);
    assign hold_full = (state == HELD);

    // State register and skid-buffer storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            hold_addr <= '0;
            hold_data <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                hold_addr <= b_addr;
                hold_data <= b_data;
            end
        end
    end

    // Arbitration: held entry first, then A, then B; conflicting B is captured.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        capture    = 1'b0;
        issue_addr = hold_addr;
        issue_data = hold_data;
        unique case (state)
            EMPTY: begin
                if (a_valid) begin
                    issue      = 1'b1;
                    issue_addr = a_addr;
                    issue_data = a_data;
                    if (b_valid) begin
                        capture    = 1'b1;
                        state_next = HELD;
                    end
                end else if (b_valid) begin
                    issue      = 1'b1;
                    issue_addr = b_addr;
                    issue_data = b_data;
                end
            end
            HELD: begin
                issue      = 1'b1;
                state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    // Strobe qualification and one-hot decode of the issued address.
    always_comb begin
`ifdef REGFILE_WR_ZERO_PROTECT_EN
        issue_en = issue && (issue_addr != '0);
`else
        issue_en = issue;
`endif
        issue_sel = '0;
        if (issue_en) begin
            issue_sel = {{(NREG-1){1'b0}}, 1'b1} << issue_addr;
        end
    end

    // Registered write-port outputs; address/data hold when nothing issues.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_sel  <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en  <= issue_en;
            wr_sel <= issue_sel;
            if (issue) begin
                wr_addr <= issue_addr;
                wr_data <= issue_data;
            end
        end
    end

endmodule
